// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
//  Module      : mdu
//  Description : Iterative multiply/divide unit owning the HI/LO registers.
//                A mult/div is accepted while idle, the result is computed
//                from the operands captured at the accepting edge, held in
//                pending registers, and committed to HI/LO after MUL_CYCLES
//                or DIV_CYCLES busy cycles. mthi/mtlo write HI/LO directly.
//  Ports       : clk    - clock, all state changes on its rising edge
//                reset  - synchronous active-high reset
//                srcA   - operand A (rs value)
//                srcB   - operand B (rt value)
//                mdOp   - request: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                         5 mthi, 6 mtlo, 7 reserved (none)
//                busy   - high while a mult/div is in flight
//                hi     - architectural HI register
//                lo     - architectural LO register
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic [2:0]  mdOp,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int c_MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = (c_MAX_CYCLES > 1) ? $clog2(c_MAX_CYCLES) : 1;

    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(DIV_CYCLES - 1);

    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt,   w_cnt_nxt;
    logic [31:0]          r_hi,    w_hi_nxt;
    logic [31:0]          r_lo,    w_lo_nxt;
    logic [31:0]          r_pend_hi, w_pend_hi_nxt;
    logic [31:0]          r_pend_lo, w_pend_lo_nxt;
    logic                 r_div_zero, w_div_zero_nxt;

    // ------------------------------------------------------------------
    // Arithmetic on the live operands; only sampled on the accepting edge.
    // The low 64 bits of a 64x64 product of sign-extended operands equal
    // the signed 32x32 product, so both flavours share one unsigned form.
    // ------------------------------------------------------------------
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    assign w_prod_s = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
    assign w_prod_u = {32'd0, srcA} * {32'd0, srcB};

    // Signed division done on magnitudes: quotient truncates toward zero and
    // the remainder follows the dividend's sign. The magnitude of 0x80000000
    // is representable unsigned, so INT_MIN / -1 naturally yields 0x80000000
    // with remainder 0 without a special case.
    logic        w_signed_div;
    logic        w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag, w_b_safe;
    logic [31:0] w_q_mag, w_r_mag;
    logic [31:0] w_quot, w_rem;

    assign w_signed_div = (mdOp == c_OP_DIV);
    assign w_a_neg      = w_signed_div & srcA[31];
    assign w_b_neg      = w_signed_div & srcB[31];
    assign w_a_mag      = w_a_neg ? (32'd0 - srcA) : srcA;
    assign w_b_mag      = w_b_neg ? (32'd0 - srcB) : srcB;
    // Divisor of zero is replaced to keep the divider well defined; the
    // result is discarded at commit anyway.
    assign w_b_safe     = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag      = w_a_mag / w_b_safe;
    assign w_r_mag      = w_a_mag % w_b_safe;
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem        = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_hi_nxt       = r_hi;
        w_lo_nxt       = r_lo;
        w_pend_hi_nxt  = r_pend_hi;
        w_pend_lo_nxt  = r_pend_lo;
        w_div_zero_nxt = r_div_zero;

        case (r_state)
            S_IDLE: begin
                case (mdOp)
                    c_OP_MULT, c_OP_MULTU: begin
                        w_pend_hi_nxt  = (mdOp == c_OP_MULT) ? w_prod_s[63:32] : w_prod_u[63:32];
                        w_pend_lo_nxt  = (mdOp == c_OP_MULT) ? w_prod_s[31:0]  : w_prod_u[31:0];
                        w_div_zero_nxt = 1'b0;
                        w_cnt_nxt      = c_MUL_LOAD;
                        w_state_nxt    = S_BUSY;
                    end
                    c_OP_DIV, c_OP_DIVU: begin
                        w_pend_hi_nxt  = w_rem;
                        w_pend_lo_nxt  = w_quot;
                        w_div_zero_nxt = (srcB == 32'd0);
                        w_cnt_nxt      = c_DIV_LOAD;
                        w_state_nxt    = S_BUSY;
                    end
                    c_OP_MTHI: w_hi_nxt = srcA;
                    c_OP_MTLO: w_lo_nxt = srcA;
                    default: ;
                endcase
            end
            S_BUSY: begin
                // Requests are ignored here; the controller stalls instead.
                if (r_cnt == '0) begin
                    if (!r_div_zero) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_pend_hi  <= 32'd0;
            r_pend_lo  <= 32'd0;
            r_div_zero <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hi       <= w_hi_nxt;
            r_lo       <= w_lo_nxt;
            r_pend_hi  <= w_pend_hi_nxt;
            r_pend_lo  <= w_pend_lo_nxt;
            r_div_zero <= w_div_zero_nxt;
        end
    end

    assign busy = (r_state == S_BUSY);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire
